// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Fetch-buffer entry layout, FSM states and opcode helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP_DEF = 6'b111111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  function automatic logic is_halt(
    input logic [31:0] w,
    input logic [5:0]  op
  );
    return w[OPCODE_MSB:OPCODE_LSB] == op;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-to-decode handshake bundle.
// Master drives the buffered instruction, slave drives ready.
interface inst_fetch_ctrl_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output out_valid,
    output out_inst,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_inst,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer of {pc, inst} fetch results.
// Flush empties it; push and pop may share an edge.
import fetch_pkg::*;

module fetch_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_ent_t din,
  output fetch_ent_t head,
  output logic [1:0] count
);

  fetch_ent_t mem [2];
  logic       rd;
  logic       wr;

  // storage, pointers and occupancy; flush drops everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd    <= 1'b0;
      wr    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= ~wr;
      end
      if (pop) begin
        rd <= ~rd;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: PC, ROM address, output buffer.
// Handles run/pause, redirect with flush and halt-on-opcode.
import fetch_pkg::*;

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_BITS = 8,
  parameter logic [5:0]  HALT_OP   = HALT_OP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [31:0]        rom_addr,
  input  logic [31:0]        rom_inst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  inst_fetch_ctrl_if.master  out,
  output logic               halted
);

  fetch_state_t         state;
  fetch_state_t         state_nx;
  logic [ADDR_BITS-1:0] pc;
  logic [ADDR_BITS-1:0] pc_nx;
  logic [1:0]           count;
  logic                 pop;
  logic                 room;
  logic                 push;
  logic                 hit_halt;
  fetch_ent_t           din;
  fetch_ent_t           head;
  logic                 unused_bits;

  assign unused_bits = ^{redirect_pc[31:ADDR_BITS],
                         redirect_pc[1:0]};

  assign rom_addr = {{(32-ADDR_BITS){1'b0}}, pc};

  assign pop  = out.out_valid & out.out_ready;
  assign room = (count - {1'b0, pop}) < 2'd2;
  assign push = ~redirect_valid & run & room
              & (state == ST_FETCH);

  assign hit_halt = is_halt(rom_inst, HALT_OP);
  assign din      = {rom_addr, rom_inst};

  // next state: redirect dominates, then run/halt rules
  always_comb begin
    state_nx = state;
    if (redirect_valid) begin
      state_nx = run ? ST_FETCH : ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run) state_nx = ST_FETCH;
        end
        ST_FETCH: begin
          if (!run)                 state_nx = ST_IDLE;
          else if (push && hit_halt) state_nx = ST_HALT;
        end
        ST_HALT: state_nx = ST_HALT;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // next PC: redirect target, or advance only with an enqueue
  always_comb begin
    pc_nx = pc;
    unique case (1'b1)
      redirect_valid:
        pc_nx = {redirect_pc[ADDR_BITS-1:2], 2'b00};
      push:
        pc_nx = pc + ADDR_BITS'(4);
      default: pc_nx = pc;
    endcase
  end

  // state and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC[ADDR_BITS-1:0];
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign out.out_valid = (count != 2'd0);
  assign out.out_inst  = head.inst;
  assign out.out_pc    = head.pc;
  assign halted        = (state == ST_HALT);

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch sequencer sitting between the core and the 64-word combinational instruction ROM. Owns the program counter, drives the ROM byte address, captures each returned word with its PC into a 2-entry output buffer, and hands it to decode over a valid/ready handshake. Supports run/pause, branch/jump redirect with flush, and halt-on-opcode.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset; low 2 bits must be zero.
- ADDR_BITS, 8, PC wraps modulo 2^ADDR_BITS; 8 matches the 64-word ROM.
- HALT_OP, 6'b111111, opcode in inst[31:26] that stops fetching.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  fetch enable; 0 pauses fetch, buffer still drains.
- rom_addr  out  32  byte address to ROM, equal to the current PC.
- rom_inst  in  32  ROM word for rom_addr, valid in the same cycle (combinational ROM).
- redirect_valid  in  1  one-cycle redirect request.
- redirect_pc  in  32  redirect target; bits [1:0] ignored.
- out_valid  out  1  buffer head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  32  PC of the head instruction.
- halted  out  1  high while in HALT.

## Operation
- States: IDLE, FETCH, HALT.
  - IDLE→FETCH when run=1.
  - FETCH→IDLE when run=0.
  - FETCH→HALT on the edge that enqueues a word with inst[31:26]==HALT_OP.
  - HALT→FETCH only on redirect.
  - Any state→FETCH on redirect_valid when run=1; →IDLE on redirect when run=0.
- Fetch: in FETCH with buffer count <2 (after the same-cycle dequeue), enqueue {PC, rom_inst} and set PC ← (PC+4) mod 2^ADDR_BITS. Upper bits of PC above ADDR_BITS are always zero.
- The halt word itself is enqueued and delivered; nothing after it is fetched. PC stays pointing past it.
- Redirect has the highest priority:
  - Flush the buffer.
  - PC ← {redirect_pc[ADDR_BITS-1:2],2'b00}, upper bits zero.
  - No enqueue on that edge.
  - A head handshake (out_valid & out_ready) on the same edge counts as delivered; the flush removes only the remaining entries.
- Buffer: 2-entry FIFO, in-order. Enqueue and dequeue can happen on the same edge. When full, an enqueue is allowed only if a dequeue happens on the same edge. The PC never advances without an enqueue.
- rom_addr = PC, combinational from the PC register.

## Timing
- Reset values:
  - PC=RESET_PC, so rom_addr=RESET_PC.
  - State=IDLE, buffer empty.
  - out_valid=0, out_inst=0, out_pc=0, halted=0.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous); buffered words are lost.
- Latency: with run=1 from the first edge after reset release, the state enters FETCH at edge 1 and the first enqueue happens at edge 2.
- out_valid is registered and goes high the cycle after enqueue.
- Sustained throughput is 1 instruction/cycle with out_ready held at 1.
- Redirect: the target word is enqueued on the edge after the redirect and is visible on out_* one cycle later, so there are 2 bubble cycles.
- out_inst/out_pc hold steady while out_valid=1 and out_ready=0.
- Wrap: PC=2^ADDR_BITS−4 fetches, then PC=0.

## Structure
- Package fetch_pkg:
  - fetch_state_t enum (IDLE, FETCH, HALT).
  - OPCODE_MSB/LSB (31/26).
  - NOP word 32'h0000_0000.
  - Default HALT_OP.
- Sub-module fetch_buf: a 2-entry 64-bit FIFO with push, pop, flush, count, and head outputs.
- FSM and PC logic live in inst_fetch_ctrl.

## Test plan
- Straight-line fetch: reset, run=1, out_ready=1, ROM words 0..3 distinct.
  - Expect out_pc = 0,4,8,C on consecutive cycles from cycle 3, matching inst.
- Backpressure: out_ready=0 for 5 cycles.
  - Buffer fills to 2 and PC stops at 8.
  - Release: out_pc 0,4,8 delivered in order with no loss or duplicate.
- Redirect with simultaneous handshake: buffer holds PCs 4,8 with the head accepted; redirect_pc=32'h0000_0023.
  - Expect PC 4 delivered, PC 8 dropped.
  - Next delivered out_pc=0x20.
- Halt: word at 0x08 = {6'b111111,26'h0}.
  - Expect the word at 0x08 delivered, halted=1, no out_pc 0x0C.
  - Redirect to 0 restarts fetch and clears halted.
- Wrap and pause: RESET_PC=0xF8.
  - Expect out_pc F8, FC, 0.
  - run=0 mid-stream: the buffer drains and no new PCs appear.
  - Async rst_n pulse mid-stream: out_valid=0 immediately and PC=0xF8.
